// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Purpose:
//   Decides which of NUM_MASTERS master ports owns the shared serial system
//   bus. A master raises its request and holds it for the whole transaction.
//   The arbiter returns a registered one-hot grant and keeps it until the owner
//   drops its request. There is no preemption. Every release is followed by
//   exactly one turnaround cycle with no grant before the next owner is
//   granted. The arbiter also counts how long the current tenure has lasted
//   and raises a one-cycle warning pulse when the tenure becomes too long. It
//   never revokes the grant on its own.
//
// Parameters:
//   NUM_MASTERS     number of requesting masters (2..16)
//   RR_EN           1 = round-robin, 0 = fixed priority (index 0 highest)
//   TIMEOUT_CYCLES  tenure length that raises timeout_err; 0 disables the check
//   MSEL_WIDTH      width of msel, at least clog2(NUM_MASTERS), minimum 1
//
// Ports:
//   clk          in   rising-edge clock
//   rstn         in   synchronous, active-low reset
//   breq         in   per-master request, level, held for the whole transaction
//   bgrant       out  registered one-hot grant (all zero when nobody owns the bus)
//   msel         out  index of the current or most recent owner (bus mux select)
//   bus_busy     out  1 while a grant is asserted
//   timeout_err  out  one-cycle pulse on the TIMEOUT_CYCLES-th cycle of a tenure
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int RR_EN          = 1,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MSEL_WIDTH     = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] breq,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [MSEL_WIDTH-1:0]  msel,
    output logic                   bus_busy,
    output logic                   timeout_err
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // The counter holds (tenure cycle - 1). The pulse is therefore registered
    // at the edge where the counter still reads TIMEOUT_CYCLES-2, so that it
    // becomes visible during tenure cycle TIMEOUT_CYCLES. A limit of 1 has no
    // earlier edge, so it is handled at the granting edge instead.
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = (TIMEOUT_CYCLES >= 2) ?
                                            CNT_W'(TIMEOUT_CYCLES - 2) : '0;
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] bgrant_q;
    logic [MSEL_WIDTH-1:0]  msel_q;
    logic                   busy_q;
    logic                   tout_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [PTR_W-1:0]       ptr_q;

    // Winner selection
    logic             win_vld_d;
    logic [PTR_W-1:0] win_idx_d;
    logic             hi_vld, lo_vld;
    logic [PTR_W-1:0] hi_idx, lo_idx;
    logic             own_req;

    // The request vector is split at the rr pointer. "hi" is the lowest
    // requester above the pointer and "lo" is the lowest requester at or below
    // it. Taking hi first gives the modulo search that starts at ptr+1. The
    // previous owner sits at the pointer, so it falls into lo and gets the
    // lowest priority. With fixed priority every requester lands in lo, so the
    // lowest index wins.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (breq[i]) begin
                if (RR_EN == 0 || i <= int'(ptr_q)) begin
                    lo_vld = 1'b1;
                    lo_idx = PTR_W'(i);
                end else begin
                    hi_vld = 1'b1;
                    hi_idx = PTR_W'(i);
                end
            end
        end
        win_vld_d = hi_vld | lo_vld;
        win_idx_d = hi_vld ? hi_idx : lo_idx;
    end

    // Masking with the one-hot grant picks out only the owner's request.
    // An X on any other master's request line therefore cannot affect the
    // decision to hold the grant.
    assign own_req = |(breq & bgrant_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            bgrant_q <= '0;
            msel_q   <= '0;
            busy_q   <= 1'b0;
            tout_q   <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= PTR_RST;
        end else begin
            tout_q <= 1'b0;
            case (state_q)
                // The turnaround cycle arbitrates exactly like idle. It exists
                // only so that the grant is low for one cycle between owners.
                S_IDLE, S_GAP: begin
                    if (win_vld_d) begin
                        state_q  <= S_GRANT;
                        bgrant_q <= ONE_HOT0 << win_idx_d;
                        msel_q   <= MSEL_WIDTH'(win_idx_d);
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        ptr_q    <= win_idx_d;
                        tout_q   <= (TIMEOUT_CYCLES == 1);
                    end else begin
                        state_q  <= S_IDLE;
                        bgrant_q <= '0;
                        busy_q   <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (own_req) begin
                        if (TIMEOUT_CYCLES >= 2 && cnt_q == CNT_FIRE) begin
                            tout_q <= 1'b1;
                        end
                        // Saturating past the firing point keeps the pulse
                        // to a single occurrence per tenure.
                        if (TIMEOUT_CYCLES > 0 && cnt_q != CNT_SAT) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        state_q  <= S_GAP;
                        bgrant_q <= '0;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    bgrant_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bgrant      = bgrant_q;
    assign msel        = msel_q;
    assign bus_busy    = busy_q;
    assign timeout_err = tout_q;

endmodule
